// File: rtl/avr_spi_slave_pkg.sv
// avr_spi_slave_pkg
//   Shared types and constants for the AVR-to-FPGA SPI responder:
//   FSM state encoding, byte width, idle fill byte, default synchronizer
//   depth and the transmit-byte selection helper.
package avr_spi_slave_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam logic [BYTE_W-1:0] IDLE_FILL = 8'hFF;

  typedef enum logic [1:0] {
    ST_WAITCS = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SHIFT  = 2'd2
  } state_e;

  // Byte presented to the AVR: supplied data when valid, idle fill otherwise.
  function automatic logic [BYTE_W-1:0] tx_pick(input logic valid,
                                               input logic [BYTE_W-1:0] data);
    return valid ? data : IDLE_FILL;
  endfunction

endpackage

// File: rtl/avr_spi_slave_if.sv
// avr_spi_slave_if
//   Bundles the AVR SPI pins and the register-file side byte interface.
//   slave  : view used by avr_spi_slave
//   master : view used by whatever drives the pins and consumes bytes
//   Signals:
//     spics_n, spick, spido  AVR-driven SPI lines (asynchronous to fclk)
//     spidi, spidi_oe        FPGA-to-AVR data and its output enable
//     rx_data/rx_stb/rx_first received byte, strobe, first-of-frame flag
//     tx_data/tx_valid       next byte to transmit
//     cs_active, frame_end   frame-in-progress level, end-of-frame pulse
interface avr_spi_slave_if;
  import avr_spi_slave_pkg::*;

  logic              spics_n;
  logic              spick;
  logic              spido;
  logic              spidi;
  logic              spidi_oe;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_stb;
  logic              rx_first;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              cs_active;
  logic              frame_end;

  modport slave (
    input  spics_n, spick, spido, tx_data, tx_valid,
    output spidi, spidi_oe, rx_data, rx_stb, rx_first, cs_active, frame_end
  );

  modport master (
    output spics_n, spick, spido, tx_data, tx_valid,
    input  spidi, spidi_oe, rx_data, rx_stb, rx_first, cs_active, frame_end
  );
endinterface

// File: rtl/avr_spi_slave_sync.sv
// avr_spi_slave_sync
//   N-stage synchronizer followed by a registered edge detector.
//   Ports:
//     clk_i   system clock
//     rst_i   synchronous active-high reset (edge-detect state only)
//     d_i     asynchronous input
//     sync_o  synchronizer output (true pin level, N cycles late)
//     lvl_o   one extra registered copy, aligned with rise_o/fall_o
//     rise_o  one-cycle pulse, N+1 cycles after a rising pin edge
//     fall_o  one-cycle pulse, N+1 cycles after a falling pin edge
module avr_spi_slave_sync
  import avr_spi_slave_pkg::*;
#(
  parameter int unsigned STAGES  = SYNC_STAGES_DEF,
  parameter logic        RST_LVL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic sync_o,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q;
  logic              lvl_q;
  logic              rise_q;
  logic              fall_q;

  // The chain is deliberately not reset: it keeps tracking the pin while
  // rst_i is high, so the state machine sees the real level the moment
  // reset releases (needed to ignore a frame already in progress).
  always_ff @(posedge clk_i) begin
    chain_q <= {chain_q[STAGES-2:0], d_i};
  end

  // lvl_q resets to the idle level so no edge is reported for an idle line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lvl_q  <= RST_LVL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      lvl_q  <= chain_q[STAGES-1];
      rise_q <= chain_q[STAGES-1] & ~lvl_q;
      fall_q <= ~chain_q[STAGES-1] & lvl_q;
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/avr_spi_slave.sv
// avr_spi_slave
//   SPI mode-0 responder for the ATmega link, oversampled in the fclk
//   domain. Delivers each received byte with a strobe (first byte of a
//   frame flagged) and shifts out register-file bytes in the same frame.
//   Ports:
//     fclk_i       system clock, all logic on its rising edge
//     rst_i        synchronous active-high reset
//     bus          avr_spi_slave_if.slave (SPI pins + byte interface)
//     spidi_pad_o  spidi driven onto the pin, Z when not enabled
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_WAITCS | after reset; wait for spics_n high so a frame already in
//             | progress is ignored
//   ST_IDLE   | no frame; spidi released; wait for spics_n fall
//   ST_SHIFT  | frame active; shift on spick edges, drive spidi
module avr_spi_slave
  import avr_spi_slave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic           fclk_i,
  input  logic           rst_i,
  avr_spi_slave_if.slave bus,
  output wire            spidi_pad_o
);

  logic ck_rise, ck_fall, ck_sync_unused, ck_lvl_unused;
  logic cs_rise, cs_fall, cs_sync, cs_lvl;
  logic sdo_sync, sdo_lvl_unused, sdo_rise_unused, sdo_fall_unused;

  avr_spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_LVL(1'b0)) u_sync_ck (
    .clk_i (fclk_i),
    .rst_i (rst_i),
    .d_i   (bus.spick),
    .sync_o(ck_sync_unused),
    .lvl_o (ck_lvl_unused),
    .rise_o(ck_rise),
    .fall_o(ck_fall)
  );

  avr_spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_LVL(1'b1)) u_sync_cs (
    .clk_i (fclk_i),
    .rst_i (rst_i),
    .d_i   (bus.spics_n),
    .sync_o(cs_sync),
    .lvl_o (cs_lvl),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  avr_spi_slave_sync #(.STAGES(SYNC_STAGES), .RST_LVL(1'b0)) u_sync_do (
    .clk_i (fclk_i),
    .rst_i (rst_i),
    .d_i   (bus.spido),
    .sync_o(sdo_sync),
    .lvl_o (sdo_lvl_unused),
    .rise_o(sdo_rise_unused),
    .fall_o(sdo_fall_unused)
  );

  state_e            state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic              first_q, first_d;
  logic              done_q, done_d;       // a byte has completed in this frame
  logic [BYTE_W-1:0] rxsr_q, rxsr_d;
  logic [BYTE_W-1:0] txsr_q, txsr_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;
  logic              rx_stb_q, rx_stb_d;
  logic              rx_first_q, rx_first_d;
  logic              frame_end_q, frame_end_d;

  always_ff @(posedge fclk_i) begin
    if (rst_i) begin
      state_q     <= ST_WAITCS;
      bitcnt_q    <= '0;
      first_q     <= 1'b0;
      done_q      <= 1'b0;
      rxsr_q      <= '0;
      txsr_q      <= IDLE_FILL;
      rx_data_q   <= '0;
      rx_stb_q    <= 1'b0;
      rx_first_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      first_q     <= first_d;
      done_q      <= done_d;
      rxsr_q      <= rxsr_d;
      txsr_q      <= txsr_d;
      rx_data_q   <= rx_data_d;
      rx_stb_q    <= rx_stb_d;
      rx_first_q  <= rx_first_d;
      frame_end_q <= frame_end_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    first_d     = first_q;
    done_d      = done_q;
    rxsr_d      = rxsr_q;
    txsr_d      = txsr_q;
    rx_data_d   = rx_data_q;
    rx_stb_d    = 1'b0;
    rx_first_d  = rx_first_q;
    frame_end_d = 1'b0;

    case (state_q)
      ST_WAITCS: begin
        if (cs_sync) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (cs_fall) begin
          state_d  = ST_SHIFT;
          bitcnt_d = '0;
          first_d  = 1'b1;
          done_d   = 1'b0;
          txsr_d   = tx_pick(bus.tx_valid, bus.tx_data);
        end
      end

      ST_SHIFT: begin
        // cs_rise has priority: a clock edge in the same cycle is dropped,
        // and any partial byte is simply abandoned.
        if (cs_rise) begin
          state_d     = ST_IDLE;
          frame_end_d = 1'b1;
        end else if (ck_rise) begin
          rxsr_d   = {rxsr_q[BYTE_W-2:0], sdo_sync};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            rx_data_d  = {rxsr_q[BYTE_W-2:0], sdo_sync};
            rx_stb_d   = 1'b1;
            rx_first_d = first_q;
            first_d    = 1'b0;
            done_d     = 1'b1;
          end
        end else if (ck_fall) begin
          // The fall that follows a completed byte loads the next one.
          if (bitcnt_q == 3'd0 && done_q) begin
            txsr_d = tx_pick(bus.tx_valid, bus.tx_data);
          end else begin
            txsr_d = {txsr_q[BYTE_W-2:0], 1'b1};
          end
        end
      end

      default: state_d = ST_WAITCS;
    endcase
  end

  assign bus.spidi_oe  = (state_q == ST_SHIFT);
  assign bus.spidi     = (state_q == ST_SHIFT) ? txsr_q[BYTE_W-1] : 1'b1;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_stb    = rx_stb_q;
  assign bus.rx_first  = rx_first_q;
  assign bus.cs_active = ~cs_lvl;
  assign bus.frame_end = frame_end_q;

  assign spidi_pad_o = bus.spidi_oe ? bus.spidi : 1'bz;

endmodule

// File: tb/tb_avr_spi_slave.sv
module tb_avr_spi_slave;
  import avr_spi_slave_pkg::*;

  localparam int NS   = 2;
  localparam int HMIN = NS + 2;

  logic fclk = 1'b0;
  logic rst  = 1'b1;
  always #5 fclk = ~fclk;

  avr_spi_slave_if sif ();
  wire spidi_pad;

  avr_spi_slave #(.SYNC_STAGES(NS)) dut (
    .fclk_i     (fclk),
    .rst_i      (rst),
    .bus        (sif),
    .spidi_pad_o(spidi_pad)
  );

  int total = 0;
  int bad   = 0;
  int phase = 3;
  int fe_seen = 0;
  int fe_exp  = 0;

  logic [8:0] exp_rx_q[$];   // {first, byte} expected per rx_stb
  logic [8:0] mon_e;
  logic [7:0] f_rx[$];       // bytes the AVR sends in the next frame
  logic [8:0] f_tx[$];       // {valid, data} offered for byte 0, 1, ...

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Monitor: every rx_stb pops one expected byte.
  always @(negedge fclk) begin
    if (sif.rx_stb) begin
      total++;
      if (exp_rx_q.size() == 0) begin
        bad++;
        $display("FAIL rx_stb_spurious: got data=%0h first=%0b expected no strobe at %0t",
                 sif.rx_data, sif.rx_first, $time);
      end else begin
        total--;
        mon_e = exp_rx_q.pop_front();
        check("rx_data", 32'(sif.rx_data), 32'(mon_e[7:0]));
        check("rx_first", 32'(sif.rx_first), 32'(mon_e[8]));
      end
    end
    if (sif.frame_end) fe_seen++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge fclk);
    #(phase);
  endtask

  // AVR side of one frame: f_rx full bytes plus 'partial' extra bits.
  task automatic run_frame(input int half, input int partial);
    logic [7:0] sbytes[$];
    logic [7:0] cur;
    logic [7:0] got;
    logic [7:0] exp_b;
    logic [8:0] ent;
    int nb, ntot, idx;
    nb = f_rx.size();
    sbytes = f_rx;
    if (partial > 0) sbytes.push_back(8'($urandom));
    ntot = nb * 8 + partial;
    for (int i = 0; i < nb; i++) exp_rx_q.push_back({(i == 0), f_rx[i]});
    ent = f_tx[0];
    sif.tx_valid = ent[8];
    sif.tx_data  = ent[7:0];
    cur = sbytes[0];
    sif.spido = cur[7];
    sif.spics_n = 1'b0;
    step(half);
    check("cs_active", 32'(sif.cs_active), 32'd1);
    got = '0;
    for (int k = 0; k < ntot; k++) begin
      got = {got[6:0], spidi_pad};
      sif.spick = 1'b1;
      step(half);
      sif.spick = 1'b0;
      if (k % 8 == 7) begin
        idx = k / 8;
        ent = f_tx[idx];
        exp_b = ent[8] ? ent[7:0] : 8'hFF;
        check("avr_rx_byte", 32'(got), 32'(exp_b));
        if (idx + 1 < f_tx.size()) begin
          ent = f_tx[idx + 1];
          sif.tx_valid = ent[8];
          sif.tx_data  = ent[7:0];
        end
      end
      if (k + 1 < ntot) begin
        cur = sbytes[(k + 1) / 8];
        sif.spido = cur[7 - ((k + 1) % 8)];
      end
      step(half);
    end
    sif.spics_n = 1'b1;
    fe_exp++;
    step(NS + 4);
    check("frame_end_count", 32'(fe_seen), 32'(fe_exp));
    check("oe_after_frame", 32'(sif.spidi_oe), 32'd0);
    check("spidi_after_frame", 32'(sif.spidi), 32'd1);
    sif.tx_valid = 1'b0;
  endtask

  initial begin
    sif.spics_n  = 1'b1;
    sif.spick    = 1'b0;
    sif.spido    = 1'b0;
    sif.tx_data  = 8'h00;
    sif.tx_valid = 1'b0;
    rst = 1'b1;
    step(6);
    check("rst_spidi", 32'(sif.spidi), 32'd1);
    check("rst_spidi_oe", 32'(sif.spidi_oe), 32'd0);
    check("rst_rx_data", 32'(sif.rx_data), 32'd0);
    check("rst_rx_stb", 32'(sif.rx_stb), 32'd0);
    check("rst_rx_first", 32'(sif.rx_first), 32'd0);
    check("rst_cs_active", 32'(sif.cs_active), 32'd0);
    check("rst_frame_end", 32'(sif.frame_end), 32'd0);
    rst = 1'b0;
    step(2 * NS + 4);

    // Two-byte frame with known data both ways.
    f_rx = '{8'hA5, 8'h3C};
    f_tx = '{9'h196, 9'h10F, 9'h000};
    run_frame(6, 0);
    step(5);

    // tx_valid low throughout: AVR reads idle fill.
    f_rx.delete(); f_tx.delete();
    for (int i = 0; i < 3; i++) f_rx.push_back(8'($urandom));
    for (int i = 0; i < 4; i++) f_tx.push_back({1'b0, 8'($urandom)});
    run_frame(5, 0);
    step(5);

    // CS released 5 bits into byte 2, then a one-byte frame.
    f_rx.delete(); f_tx.delete();
    f_rx.push_back(8'($urandom));
    f_tx.push_back({1'b1, 8'($urandom)});
    f_tx.push_back({1'b1, 8'($urandom)});
    run_frame(HMIN, 5);
    step(4);
    f_rx = '{8'h81};
    f_tx = '{9'h1C3, 9'h000};
    run_frame(HMIN, 0);
    step(4);

    // Reset in the middle of a byte with CS held low.
    phase = 4;
    step(1);
    sif.spics_n = 1'b0;
    step(HMIN);
    for (int k = 0; k < 3; k++) begin
      sif.spido = 1'($urandom);
      sif.spick = 1'b1; step(HMIN);
      sif.spick = 1'b0; step(HMIN);
    end
    sif.spick = 1'b1;
    step(2);
    rst = 1'b1;
    step(6);
    check("rst_mid_rx_data", 32'(sif.rx_data), 32'd0);
    check("rst_mid_oe", 32'(sif.spidi_oe), 32'd0);
    rst = 1'b0;
    step(HMIN);
    sif.spick = 1'b0;
    step(HMIN);
    for (int k = 0; k < 12; k++) begin
      sif.spido = 1'($urandom);
      sif.spick = 1'b1; step(HMIN);
      sif.spick = 1'b0; step(HMIN);
      check("post_rst_oe", 32'(sif.spidi_oe), 32'd0);
    end
    sif.spics_n = 1'b1;
    step(NS + 6);
    check("post_rst_no_frame_end", 32'(fe_seen), 32'(fe_exp));
    f_rx = '{8'h5A};
    f_tx.delete();
    f_tx.push_back({1'b1, 8'($urandom)});
    f_tx.push_back(9'h000);
    run_frame(HMIN, 0);
    step(4);

    // Minimum spick phases, random fclk phase offset, 64 random bytes.
    for (int f = 0; f < 8; f++) begin
      phase = $urandom_range(1, 9);
      step(1);
      f_rx.delete(); f_tx.delete();
      for (int i = 0; i < 8; i++) f_rx.push_back(8'($urandom));
      for (int i = 0; i < 9; i++)
        f_tx.push_back({($urandom_range(0, 3) != 0), 8'($urandom)});
      run_frame(HMIN, 0);
      step(HMIN);
    end

    // spick toggling with no frame selected.
    phase = 3;
    step(1);
    sif.spics_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      sif.spick = ~sif.spick;
      sif.spido = 1'($urandom);
      step(HMIN);
      check("idle_oe", 32'(sif.spidi_oe), 32'd0);
      check("idle_spidi", 32'(sif.spidi), 32'd1);
    end
    sif.spick = 1'b0;
    step(10);

    check("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
    check("frame_end_total", 32'(fe_seen), 32'(fe_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
